// File: rtl/load_store_unit_if.sv
// Core request/response and data-RAM bus of the RV32I load/store unit.
// The slave modport is the unit; the master modport is the core plus the RAM.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 16);
  logic                  start;
  logic                  is_load;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [31:0]           base;
  logic [31:0]           offset;
  logic [31:0]           store_data;
  logic [4:0]            rd_in;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic                  rd_write_enable;
  logic [4:0]            rd_address;
  logic [31:0]           rd_value;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_write;
  logic [31:0]           ram_write_data;
  logic [31:0]           ram_read_data;

  modport slave (
    input  start, is_load, is_store, funct3, base, offset, store_data, rd_in, ram_read_data,
    output busy, done, fault, rd_write_enable, rd_address, rd_value,
           ram_address, ram_write, ram_write_data
  );

  modport master (
    output start, is_load, is_store, funct3, base, offset, store_data, rd_in, ram_read_data,
    input  busy, done, fault, rd_write_enable, rd_address, rd_value,
           ram_address, ram_write, ram_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-wide synchronous-read RAM without byte enables.
// Sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic                  rd_write_enable_q, rd_write_enable_d;
  logic [4:0]            rd_address_q, rd_address_d;
  logic [31:0]           rd_value_q, rd_value_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic                  ram_write_q, ram_write_d;
  logic [31:0]           ram_write_data_q, ram_write_data_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_load_q, is_load_d;
  logic [15:0]           store_data_q, store_data_d;

  logic [ADDR_WIDTH-1:0] ea_s;
  logic                  legal_s;
  logic                  misaligned_s;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] lane, input logic [2:0] f3);
    logic [31:0] r;
    r = word;
    case (f3[1:0])
      2'b00: r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (lane[1]) begin
          r[31:16] = data;
        end else begin
          r[15:0] = data;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Only the low ADDR_WIDTH bits of the effective address reach the RAM, so a narrow add suffices.
  always_comb begin
    ea_s = bus.base[ADDR_WIDTH-1:0] + bus.offset[ADDR_WIDTH-1:0];
    if (bus.is_load && !bus.is_store) begin
      legal_s = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (bus.is_store && !bus.is_load) begin
      legal_s = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal_s = 1'b0;
    end
    case (bus.funct3[1:0])
      2'b01:   misaligned_s = ea_s[0];
      2'b10:   misaligned_s = (ea_s[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      fault_q           <= 1'b0;
      rd_write_enable_q <= 1'b0;
      rd_address_q      <= 5'd0;
      rd_value_q        <= 32'd0;
      ram_address_q     <= {ADDR_WIDTH{1'b0}};
      ram_write_q       <= 1'b0;
      ram_write_data_q  <= 32'd0;
      funct3_q          <= 3'd0;
      is_load_q         <= 1'b0;
      store_data_q      <= 16'd0;
    end else begin
      state_q           <= state_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      fault_q           <= fault_d;
      rd_write_enable_q <= rd_write_enable_d;
      rd_address_q      <= rd_address_d;
      rd_value_q        <= rd_value_d;
      ram_address_q     <= ram_address_d;
      ram_write_q       <= ram_write_d;
      ram_write_data_q  <= ram_write_data_d;
      funct3_q          <= funct3_d;
      is_load_q         <= is_load_d;
      store_data_q      <= store_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else if (!legal_s || misaligned_s) begin
          state_d = DONE;
        end else if (bus.is_store && (bus.funct3 == 3'b010)) begin
          state_d = WRITE;
        end else begin
          state_d = RD1;
        end
      end
      RD1:     state_d = RD2;
      RD2:     state_d = is_load_q ? DONE : WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; the pulse outputs fall back to zero every cycle.
  always_comb begin
    busy_d            = (state_d != IDLE);
    done_d            = (state_d == DONE);
    fault_d           = 1'b0;
    rd_write_enable_d = 1'b0;
    ram_write_d       = 1'b0;
    rd_address_d      = rd_address_q;
    rd_value_d        = rd_value_q;
    ram_address_d     = ram_address_q;
    ram_write_data_d  = ram_write_data_q;
    funct3_d          = funct3_q;
    is_load_d         = is_load_q;
    store_data_d      = store_data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          funct3_d     = bus.funct3;
          is_load_d    = bus.is_load;
          store_data_d = bus.store_data[15:0];
          if (state_d == DONE) begin
            fault_d = 1'b1;
          end else if (state_d == WRITE) begin
            ram_address_d    = ea_s;
            ram_write_data_d = bus.store_data;
            ram_write_d      = 1'b1;
          end else begin
            ram_address_d = ea_s;
            rd_address_d  = bus.rd_in;
          end
        end else begin
          fault_d = 1'b0;
        end
      end
      RD2: begin
        if (is_load_q) begin
          rd_value_d        = extend_load(bus.ram_read_data, ram_address_q[1:0], funct3_q);
          rd_write_enable_d = 1'b1;
        end else begin
          ram_write_data_d = merge_store(bus.ram_read_data, store_data_q, ram_address_q[1:0], funct3_q);
          ram_write_d      = 1'b1;
        end
      end
      default: ram_write_d = 1'b0;
    endcase
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.fault           = fault_q;
  assign bus.rd_write_enable = rd_write_enable_q;
  assign bus.rd_address      = rd_address_q;
  assign bus.rd_value        = rd_value_q;
  assign bus.ram_address     = ram_address_q;
  assign bus.ram_write_data  = ram_write_data_q;
  // A write still pending when reset arrives must never reach the RAM.
  assign bus.ram_write       = ram_write_q & reset_n;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;

  typedef struct packed {
    logic        fault;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  lat;
    logic        wexp;
    logic [15:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;
  int   start_cyc;
  int   n_done;
  int   writes_seen;
  logic [31:0] last_value;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] ram     [0:16383];
  logic [7:0]  ref_mem [0:65535];

  load_store_unit_if #(.ADDR_WIDTH(16)) bus ();

  load_store_unit #(.ADDR_WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read data RAM.
  always @(posedge clock) begin
    if (bus.ram_write) ram[bus.ram_address[15:2]] <= bus.ram_write_data;
    bus.ram_read_data <= ram[bus.ram_address[15:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    logic [15:0] wb;
    wb = {a[15:2], 2'b00};
    return {ref_mem[wb + 16'd3], ref_mem[wb + 16'd2], ref_mem[wb + 16'd1], ref_mem[wb]};
  endfunction

  // Reference model: applies the architectural effect of one request and returns its expected response.
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] b, input logic [31:0] off,
                                 input logic [31:0] sd, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] ea;
    logic [15:0] a;
    logic [31:0] v;
    int          n;
    logic        legal;
    ea = b + off;
    a  = ea[15:0];
    n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (ld && !st) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else if (st && !ld) legal = f3 inside {3'd0, 3'd1, 3'd2};
    else legal = 1'b0;
    e = '0;
    if (!legal || (a % n) != 0) begin
      e.fault = 1'b1;
      e.lat   = 4'd1;
    end else if (ld) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[a + 16'(i)]} << (8 * i));
      if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e.rd_we = 1'b1;
      e.rd    = rd;
      e.value = v;
      e.lat   = 4'd3;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + 16'(i)] = sd[8 * i +: 8];
      e.wexp  = 1'b1;
      e.waddr = a;
      e.wdata = ref_word(a);
      e.lat   = (n == 4) ? 4'd2 : 4'd4;
    end
    return e;
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
    bus.start      = 1'b1;
    bus.is_load    = ld;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.base       = b;
    bus.offset     = off;
    bus.store_data = sd;
    bus.rd_in      = rd;
  endtask

  task automatic scramble();
    bus.start      = 1'b0;
    bus.is_load    = 1'($urandom);
    bus.is_store   = 1'($urandom);
    bus.funct3     = 3'($urandom);
    bus.base       = $urandom;
    bus.offset     = $urandom;
    bus.store_data = $urandom;
    bus.rd_in      = 5'($urandom);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
    int d0;
    int waited;
    d0 = n_done;
    @(negedge clock);
    exp_q.push_back(model(ld, st, f3, b, off, sd, rd));
    drive(ld, st, f3, b, off, sd, rd);
    start_cyc = cyc;
    @(negedge clock);
    scramble();
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    waited = 0;
    while (n_done == d0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (n_done == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  // Scoreboard monitor: checks every RAM write and every completion against the queue head.
  always @(negedge clock) begin
    if (bus.ram_write) begin
      if (exp_q.size() == 0 || !exp_q[0].wexp) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr %h data %h expected no write",
                 bus.ram_address, bus.ram_write_data);
      end else begin
        check("write_addr", {16'd0, bus.ram_address}, {16'd0, exp_q[0].waddr});
        check("write_data", bus.ram_write_data, exp_q[0].wdata);
        writes_seen++;
      end
    end
    if (bus.done) begin
      n_done++;
      last_value = bus.rd_value;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("fault", {31'd0, bus.fault}, {31'd0, mon_e.fault});
        check("rd_write_enable", {31'd0, bus.rd_write_enable}, {31'd0, mon_e.rd_we});
        check("latency", 32'(cyc - start_cyc), {28'd0, mon_e.lat});
        check("write_count", 32'(writes_seen), {31'd0, mon_e.wexp});
        if (mon_e.rd_we) begin
          check("rd_address", {27'd0, bus.rd_address}, {27'd0, mon_e.rd});
          check("rd_value", bus.rd_value, mon_e.value);
        end
      end
      writes_seen = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int          d0;
    checks = 0; errors = 0; cyc = 0; start_cyc = 0; n_done = 0; writes_seen = 0;
    last_value = 32'd0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = (i == 4) ? 32'h8899_AABB : $urandom;
      ram[i] = w;
      for (int j = 0; j < 4; j++) ref_mem[i * 4 + j] = w[8 * j +: 8];
    end
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_rd_we", {31'd0, bus.rd_write_enable}, 32'd0);
    check("rst_rd_address", {27'd0, bus.rd_address}, 32'd0);
    check("rst_rd_value", bus.rd_value, 32'd0);
    check("rst_ram_address", {16'd0, bus.ram_address}, 32'd0);
    check("rst_ram_write", {31'd0, bus.ram_write}, 32'd0);
    check("rst_ram_write_data", bus.ram_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    issue(1'b1, 1'b0, 3'b000, 32'h20, 32'hFFFF_FFF1, 32'd0, 5'd3);
    check("lb_value", last_value, 32'hFFFF_FFAA);
    issue(1'b1, 1'b0, 3'b100, 32'h11, 32'd0, 32'd0, 5'd4);
    check("lbu_value", last_value, 32'h0000_00AA);
    issue(1'b1, 1'b0, 3'b101, 32'h10, 32'd2, 32'd0, 5'd5);
    check("lhu_value", last_value, 32'h0000_8899);
    issue(1'b1, 1'b0, 3'b001, 32'h12, 32'd0, 32'd0, 5'd6);
    check("lh_value", last_value, 32'hFFFF_8899);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd0);
    check("lw_value", last_value, 32'h8899_AABB);
    issue(1'b0, 1'b1, 3'b000, 32'h13, 32'd0, 32'h1234_5655, 5'd9);
    check("sb_ram_word", ram[4], 32'h5599_AABB);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd1);
    check("lw_after_sb", last_value, 32'h5599_AABB);
    issue(1'b0, 1'b1, 3'b010, 32'h14, 32'd0, 32'hDEAD_BEEF, 5'd0);
    issue(1'b0, 1'b1, 3'b001, 32'h16, 32'd0, 32'h0000_CAFE, 5'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h14, 32'd0, 32'd0, 5'd2);
    check("lw_after_sh", last_value, 32'hCAFE_BEEF);
    issue(1'b0, 1'b1, 3'b010, 32'h16, 32'd0, 32'h1111_1111, 5'd0);
    issue(1'b1, 1'b0, 3'b001, 32'h11, 32'd0, 32'd0, 5'd7);
    issue(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 5'd7);
    issue(1'b1, 1'b1, 3'b010, 32'h10, 32'd0, 32'd0, 5'd7);
    issue(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd7);

    // Spurious starts during RD1 and during DONE must be dropped.
    d0 = n_done;
    @(negedge clock);
    exp_q.push_back(model(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd8));
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd8);
    start_cyc = cyc;
    @(negedge clock);
    check("busy_rd1", {31'd0, bus.busy}, 32'd1);
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'd0, 32'hBAD0_BAD0, 5'd0);
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_rd2", {31'd0, bus.busy}, 32'd1);
    @(negedge clock);
    check("done_cycle", {31'd0, bus.done}, 32'd1);
    check("busy_done", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clock);
    check("still_idle", {31'd0, bus.busy}, 32'd0);
    check("single_done", 32'(n_done - d0), 32'd1);
    check("ignored_store_mem", ram[16], ref_word(16'h40));

    for (int k = 0; k < 150; k++) begin
      int          sel;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [15:0] tgt;
      logic [31:0] b;
      logic [31:0] off;
      sel = $urandom_range(0, 9);
      ld  = (sel == 1) || (sel >= 2 && sel <= 5);
      st  = (sel == 1) || (sel >= 6);
      f3  = 3'($urandom_range(0, 7));
      tgt = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) tgt[0] = 1'b0;
        else if (f3[1:0] != 2'd0) tgt[1:0] = 2'd0;
      end
      b   = $urandom;
      off = (($urandom & 32'hFFFF_0000) | {16'd0, tgt}) - b;
      issue(ld, st, f3, b, off, $urandom, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Reset while in WRITE: the store is abandoned and memory keeps its old contents.
    d0 = n_done;
    @(negedge clock);
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 32'h1122_3344, 5'd0);
    @(posedge clock);
    #2;
    bus.start = 1'b0;
    check("write_pending", {31'd0, bus.ram_write}, 32'd1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("abort_ram_write", {31'd0, bus.ram_write}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_mem", ram[8], ref_word(16'h20));
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against the single-port, word-wide, synchronous-read data BlockRam. It sits directly downstream of the core's ALU/decode stage and occupies the STEPLOADSTORE slot. The core pulses start with rs1, imm, rs2, funct3 and rd, then waits for done. The data RAM has no byte enables, so SB/SH are done as read-modify-write.

Parameters:
ADDR_WIDTH, 16, byte-address width presented to the data RAM. The RAM word index is address[ADDR_WIDTH-1:2].

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
is_load  input  1  request is a load
is_store  input  1  request is a store
funct3  input  3  RV32 width/sign code
base  input  32  rs1 value
offset  input  32  sign-extended imm (imm_alu_load for loads, imm_store for stores)
store_data  input  32  rs2 value
rd_in  input  5  destination register for loads
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: misaligned or illegal request
rd_write_enable  output  1  high with done for successful loads only
rd_address  output  5  latched rd_in
rd_value  output  32  extended load result
ram_address  output  ADDR_WIDTH  byte address to data RAM
ram_write  output  1  RAM write strobe
ram_write_data  output  32  RAM write word
ram_read_data  input  32  RAM read word, valid one clock after ram_address is registered

Behaviour:
- Reset: all outputs are registered and clear to 0; state becomes IDLE. Reset mid-operation aborts the operation, and any pending ram_write is dropped, never issued.
- Effective address: ea = base + offset, 32-bit wraparound. ram_address = ea[ADDR_WIDTH-1:0]; upper bits are ignored.
- Legal codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code, is_load==is_store, or both low is illegal.
- Misalignment: halfword with ea[0]=1, or word with ea[1:0]!=0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k]. A byte selects lane ea[1:0]; a halfword selects bits [31:16] if ea[1]=1, else [15:0].
- Sign handling: LB/LH sign-extend; LBU/LHU zero-extend.
- States:
  - IDLE:
    - start with illegal or misaligned request -> DONE with fault=1. No RAM write occurs.
    - SW -> latch ram_address/ram_write_data, ram_write<=1 -> WRITE.
    - Otherwise -> latch ram_address and rd -> RD1.
  - RD1: RAM samples the address -> RD2.
  - RD2: ram_read_data is valid.
    - Load: rd_value<=extended data -> DONE.
    - SB/SH: ram_write_data<=read word with the target lane(s) replaced by the low byte/half of store_data, ram_write<=1 -> WRITE.
    - store_data and funct3 are latched at start, not resampled.
  - WRITE: the RAM commits at the edge leaving this state; ram_write<=0 -> DONE.
  - DONE:
    - done=1 for exactly this cycle.
    - For a successful load, rd_write_enable=1 in the same cycle.
    - fault is valid this cycle.
    - Next edge -> IDLE, clearing done, rd_write_enable and fault.
- Latency, counted from the edge that samples start to the cycle done is high:
  - fault: 1 edge.
  - SW: 2 edges.
  - loads: 3 edges.
  - SB/SH: 4 edges.
- Handshake:
  - start is ignored while busy, including the DONE cycle.
  - The earliest next accept is the first IDLE cycle, so back-to-back issue costs one idle cycle.
  - base, offset, store_data and rd_in need only be valid on the start cycle.
- rd_write_enable is never asserted for stores or faults. rd_address=0 is passed through; the register file owns x0 handling.
- ram_write is asserted for exactly one cycle per store and never for a load or fault.

Test Plan:
- Preload word 0x0010=0x8899AABB. LB with base=0x20, offset=0xFFFFFFF1 (ea 0x11) -> 3 edges later done=1, rd_write_enable=1, rd_value=0xFFFFFFAA, ram_write stays 0.
- Same word. LBU ea=0x11 -> rd_value 0x000000AA. LHU ea=0x12 -> 0x00008899. LH ea=0x12 -> 0xFFFF8899. LW ea=0x10 -> 0x8899AABB.
- SB store_data=0x12345655 at ea=0x13 -> done 4 edges later, rd_write_enable=0. One ram_write pulse with data 0x5599AABB. A subsequent LW 0x10 returns 0x5599AABB.
- SW 0xDEADBEEF at 0x14 -> done 2 edges later, with a single ram_write pulse to address 0x14. SH 0xCAFE at 0x16 then yields word 0xCAFEBEEF.
- Misaligned SW at ea 0x16, LH at 0x11, and funct3=011 -> each gives done+fault the next cycle, with no ram_write and no rd_write_enable.
- Pulse start again during RD1 and during DONE -> both ignored; busy stays 1 until DONE. In a separate run, assert reset_n=0 while in WRITE -> ram_write=0 next cycle, memory is unchanged, and done is never pulsed.
